// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, debounced press/release detection,
// and a two-entry operand shift register feeding the seven-segment driver.
module keypad_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       pressed,
  output logic [3:0] dat1,
  output logic [3:0] dat2
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_t;

  state_t           state, state_next;
  logic [3:0]       row_meta, row_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       cap_row, cap_row_next;
  logic [3:0]       cap_code, cap_code_next;
  logic [CNT_W-1:0] stab_cnt, stab_next;
  logic [CNT_W-1:0] rel_cnt, rel_next;
  logic [3:0]       col_next, col_rot;
  logic             accept;
  logic             row_valid;
  logic [1:0]       row_idx, col_idx;

  assign tick    = (div_cnt == DIV_LAST);
  assign col_rot = {col[2:0], col[3]};

  // Exactly one low bit is a valid press; its position is the row index.
  always_comb begin
    row_valid = 1'b0;
    row_idx   = '0;
    case (row_s)
      4'b1110: begin row_valid = 1'b1; row_idx = 2'd0; end
      4'b1101: begin row_valid = 1'b1; row_idx = 2'd1; end
      4'b1011: begin row_valid = 1'b1; row_idx = 2'd2; end
      4'b0111: begin row_valid = 1'b1; row_idx = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    col_idx = '0;
    case (col)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_next    = state;
    col_next      = col;
    cap_row_next  = cap_row;
    cap_code_next = cap_code;
    stab_next     = stab_cnt;
    rel_next      = rel_cnt;
    accept        = 1'b0;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (row_valid) begin
            cap_row_next  = row_s;
            cap_code_next = {row_idx, col_idx};
            stab_next     = CNT_W'(1);
            state_next    = ST_DEBOUNCE;
          end else begin
            col_next = col_rot;
          end
        end
        ST_DEBOUNCE: begin
          if (row_s == cap_row) begin
            stab_next = stab_cnt + CNT_W'(1);
            if (stab_cnt == DEB_LAST) begin
              accept     = 1'b1;
              rel_next   = '0;
              state_next = ST_HELD;
            end
          end else begin
            state_next = ST_SCAN;
            col_next   = col_rot;
          end
        end
        ST_HELD: begin
          if (row_s == 4'hF) begin
            rel_next = rel_cnt + CNT_W'(1);
            if (rel_cnt == DEB_LAST) begin
              state_next = ST_SCAN;
              col_next   = col_rot;
            end
          end else begin
            rel_next = '0;
          end
        end
        default: state_next = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_SCAN;
      row_meta  <= '1;
      row_s     <= '1;
      div_cnt   <= '0;
      col       <= 4'b1110;
      cap_row   <= '1;
      cap_code  <= '0;
      stab_cnt  <= '0;
      rel_cnt   <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      pressed   <= 1'b0;
      dat1      <= '0;
      dat2      <= '0;
    end else begin
      row_meta  <= row;
      row_s     <= row_meta;
      div_cnt   <= tick ? '0 : div_cnt + DIV_W'(1);
      state     <= state_next;
      col       <= col_next;
      cap_row   <= cap_row_next;
      cap_code  <= cap_code_next;
      stab_cnt  <= stab_next;
      rel_cnt   <= rel_next;
      key_valid <= accept;
      pressed   <= (state_next == ST_HELD);
      if (accept) begin
        key  <= cap_code;
        dat1 <= dat2;
        dat2 <= cap_code;
      end
    end
  end

endmodule
